// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : cacheline_adaptor
//  Description : Bridges a line-wide cache request interface to a burst-based
//                physical memory interface. A line read is assembled from
//                num_beats memory beats; a line write is split into num_beats
//                beats. Each beat advances only when memory acknowledges it
//                with resp_i.
//
//  Ports
//    clk        : clock, all state updates on the rising edge
//    rst        : synchronous active-high reset
//    line_i     : write line from the cache
//    line_o     : assembled read line returned to the cache
//    address_i  : request address from the cache
//    read_i     : line read request (held until resp_o)
//    write_i    : line write request (held until resp_o), wins over read_i
//    resp_o     : single-cycle completion pulse to the cache
//    burst_i    : read beat from memory
//    burst_o    : write beat to memory
//    address_o  : line-aligned burst address to memory
//    read_o     : burst read request to memory
//    write_o    : burst write request to memory
//    resp_i     : per-beat acknowledge from memory
//
//  Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adaptor #(
    parameter int s_line    = 256,
    parameter int s_burst   = 64,
    parameter int num_beats = s_line / s_burst
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int c_cnt_w = (num_beats > 1) ? $clog2(num_beats) : 1;

    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_read       = 3'd1;
    localparam logic [2:0] c_st_read_done  = 3'd2;
    localparam logic [2:0] c_st_write      = 3'd3;
    localparam logic [2:0] c_st_write_done = 3'd4;

    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(num_beats - 1);

    // Memory bursts are always issued from a 32-byte aligned address.
    localparam logic [31:0] c_addr_mask = 32'hFFFF_FFE0;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_address;
    logic [s_line-1:0]  r_line;
    logic [s_line-1:0]  r_wline;
    logic [s_burst-1:0] w_wbeat;

    // Select the write beat addressed by the beat counter.
    always_comb begin
        w_wbeat = '0;
        for (int k = 0; k < num_beats; k++) begin
            if (r_cnt == c_cnt_w'(k)) begin
                w_wbeat = r_wline[k*s_burst +: s_burst];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_address <= '0;
            r_line    <= '0;
            r_wline   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (write_i) begin
                        r_address <= address_i & c_addr_mask;
                        r_wline   <= line_i;
                        r_cnt     <= '0;
                        r_state   <= c_st_write;
                    end else if (read_i) begin
                        r_address <= address_i & c_addr_mask;
                        r_cnt     <= '0;
                        r_state   <= c_st_read;
                    end
                end

                c_st_read: begin
                    if (resp_i) begin
                        for (int k = 0; k < num_beats; k++) begin
                            if (r_cnt == c_cnt_w'(k)) begin
                                r_line[k*s_burst +: s_burst] <= burst_i;
                            end
                        end
                        // Counter holds on the final beat so it never wraps.
                        if (r_cnt == c_last_beat) begin
                            r_state <= c_st_read_done;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                c_st_write: begin
                    if (resp_i) begin
                        if (r_cnt == c_last_beat) begin
                            r_state <= c_st_write_done;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                c_st_read_done:  r_state <= c_st_idle;
                c_st_write_done: r_state <= c_st_idle;
                default:         r_state <= c_st_idle;
            endcase
        end
    end

    // Outputs are forced quiet while reset is asserted so they are defined
    // even before the first reset edge has loaded the state register.
    assign read_o    = !rst && (r_state == c_st_read);
    assign write_o   = !rst && (r_state == c_st_write);
    assign resp_o    = !rst && ((r_state == c_st_read_done) || (r_state == c_st_write_done));
    assign burst_o   = write_o ? w_wbeat : '0;
    assign address_o = r_address;
    assign line_o    = r_line;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cacheline_adaptor
//  Description : Scoreboard testbench for cacheline_adaptor. Stimulus tasks
//                push expected line transactions and write beats into queues;
//                a monitor on the falling edge pops and compares them whenever
//                the DUT completes a transfer or presents an acknowledged beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit           is_wr;
        logic [31:0]  addr;
        logic [255:0] line;
    } txn_t;

    txn_t        txnq[$];
    logic [63:0] beatq[$];
    txn_t        mon_t;
    logic [63:0] mon_b;

    localparam logic [63:0] c_junk = 64'hDEAD_BEEF_BAAD_F00D;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares completed transfers and acknowledged write beats.
    always @(negedge clk) begin
        if (!rst) begin
            check("rw_exclusive", {255'd0, read_o & write_o}, 256'd0);
            if (resp_o) begin
                if (txnq.size() == 0) begin
                    check("spurious_resp", 256'd1, 256'd0);
                end else begin
                    mon_t = txnq.pop_front();
                    check("resp_address", {224'd0, address_o}, {224'd0, mon_t.addr});
                    if (!mon_t.is_wr) check("read_line", line_o, mon_t.line);
                end
            end
            if (write_o && resp_i) begin
                if (beatq.size() == 0) begin
                    check("spurious_beat", 256'd1, 256'd0);
                end else begin
                    mon_b = beatq.pop_front();
                    check("write_beat", {192'd0, burst_o}, {192'd0, mon_b});
                end
            end
        end
    end

    // One line transfer. pat gives resp_i per cycle (LSB first) for len cycles.
    // In the resp_o cycle the requests are set to nxt_rd/nxt_wr, then one more
    // cycle (IDLE) is consumed.
    task automatic xfer(input bit wr, input bit rd_too, input logic [31:0] addr,
                        input logic [255:0] wline,
                        input logic [63:0] b0, input logic [63:0] b1,
                        input logic [63:0] b2, input logic [63:0] b3,
                        input logic [15:0] pat, input int len,
                        input bit nxt_rd, input bit nxt_wr);
        logic [63:0] beats[4];
        txn_t        t;
        int          idx;
        beats   = '{b0, b1, b2, b3};
        t.is_wr = wr;
        t.addr  = {addr[31:5], 5'd0};
        t.line  = wr ? wline : {b3, b2, b1, b0};
        txnq.push_back(t);
        if (wr) begin
            for (int k = 0; k < 4; k++) beatq.push_back(wline[k*64 +: 64]);
        end
        address_i = addr;
        line_i    = wline;
        write_i   = wr;
        read_i    = wr ? rd_too : 1'b1;
        @(posedge clk); #1;
        check(wr ? "start_write" : "start_read", {254'd0, read_o, write_o},
              wr ? 256'd1 : 256'd2);
        idx = 0;
        for (int i = 0; i < len; i++) begin
            if (wr) check("no_read_o_in_write", {255'd0, read_o}, 256'd0);
            resp_i  = pat[i];
            burst_i = pat[i] ? beats[idx] : c_junk;
            if (pat[i]) idx++;
            @(posedge clk); #1;
        end
        resp_i  = 1'b0;
        burst_i = c_junk;
        check("resp_pulse", {255'd0, resp_o}, 256'd1);
        check("done_quiet", {254'd0, read_o, write_o}, 256'd0);
        read_i  = nxt_rd;
        write_i = nxt_wr;
        @(posedge clk); #1;
        check("resp_single", {255'd0, resp_o}, 256'd0);
        check("idle_quiet", {254'd0, read_o, write_o}, 256'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {252'd0, resp_o, read_o, write_o, |burst_o}, 256'd0);
        check("rst_address", {224'd0, address_o}, 256'd0);
        check("rst_line", line_o, 256'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic read, continuous acknowledge.
        xfer(1'b0, 1'b0, 32'h1234_5678, 256'd0,
             64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
             64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444,
             16'h000F, 4, 1'b0, 1'b0);

        // Basic write, beats A,B,C,D in order.
        xfer(1'b1, 1'b0, 32'h0000_105F,
             {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
             64'd0, 64'd0, 64'd0, 64'd0, 16'h000F, 4, 1'b0, 1'b0);

        // Read with stalling acknowledge 1,0,0,1,1,0,1.
        xfer(1'b0, 1'b0, 32'hCAFE_00E1, 256'd0,
             64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
             64'h2122_2324_2526_2728, 64'h3132_3334_3536_3738,
             16'h0059, 7, 1'b0, 1'b0);

        // read_i and write_i together: write only, stalling acknowledge.
        xfer(1'b1, 1'b1, 32'h8000_0004,
             {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
              64'h5555_5555_5555_5555, 64'h9999_9999_9999_9999},
             64'd0, 64'd0, 64'd0, 64'd0, 16'h0035, 6, 1'b0, 1'b0);

        // Reset after two read beats abandons the transfer.
        address_i = 32'h0000_2000;
        read_i    = 1'b1;
        @(posedge clk); #1;
        resp_i = 1'b1; burst_i = 64'h7777_7777_7777_7777;
        @(posedge clk); #1;
        burst_i = 64'h8888_8888_8888_8888;
        @(posedge clk); #1;
        rst = 1'b1; resp_i = 1'b0; read_i = 1'b0; burst_i = c_junk;
        @(posedge clk); #1;
        check("rst_mid_quiet", {253'd0, resp_o, read_o, write_o}, 256'd0);
        check("rst_mid_line", line_o, 256'd0);
        check("rst_mid_address", {224'd0, address_o}, 256'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", {253'd0, resp_o, read_o, write_o}, 256'd0);

        // Normal read after reset, then write->read->read held back-to-back.
        xfer(1'b0, 1'b0, 32'h0000_3FFF, 256'd0,
             64'hA1A1_A1A1_A1A1_A1A1, 64'hB2B2_B2B2_B2B2_B2B2,
             64'hC3C3_C3C3_C3C3_C3C3, 64'hD4D4_D4D4_D4D4_D4D4,
             16'h000F, 4, 1'b0, 1'b0);
        xfer(1'b1, 1'b0, 32'h4444_0020,
             {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
              64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001},
             64'd0, 64'd0, 64'd0, 64'd0, 16'h000F, 4, 1'b1, 1'b0);
        xfer(1'b0, 1'b0, 32'h5555_0040, 256'd0,
             64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF,
             64'h1357_9BDF_2468_ACE0, 64'h0F1E_2D3C_4B5A_6978,
             16'h000F, 4, 1'b1, 1'b0);
        xfer(1'b0, 1'b0, 32'h5555_0040, 256'd0,
             64'h6666_6666_6666_6666, 64'h7777_7777_7777_7777,
             64'h8888_8888_8888_8888, 64'h9999_9999_9999_9999,
             16'h001B, 5, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("txn_queue_drained", 256'(txnq.size()), 256'd0);
        check("beat_queue_drained", 256'(beatq.size()), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter s_line, default 256: cache line width in bits.
REQ-002 Parameter s_burst, default 64: physical memory beat width in bits.
REQ-003 Parameter num_beats, default s_line/s_burst (4): beats per line transfer.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port line_i  input  s_line: write line from the cache.
REQ-007 Port line_o  output  s_line: read line returned to the cache.
REQ-008 Port address_i  input  32: line request address from the cache.
REQ-009 Port read_i  input  1: line read request; held by the cache until resp_o.
REQ-010 Port write_i  input  1: line write request; held by the cache until resp_o.
REQ-011 Port resp_o  output  1: single-cycle completion pulse to the cache.
REQ-012 Port burst_i  input  s_burst: read beat from physical memory.
REQ-013 Port burst_o  output  s_burst: write beat to physical memory.
REQ-014 Port address_o  output  32: line-aligned burst address to physical memory.
REQ-015 Port read_o  output  1: burst read request to physical memory.
REQ-016 Port write_o  output  1: burst write request to physical memory.
REQ-017 Port resp_i  input  1: per-beat acknowledge from physical memory.

Function
REQ-018 States: IDLE, READ, READ_DONE, WRITE, WRITE_DONE.
REQ-019 IDLE with read_i=1, write_i=0: latch address_i with bits [4:0] cleared into address_o, clear beat counter, go to READ.
REQ-020 IDLE with write_i=1: latch address_i (bits [4:0] cleared) and line_i, clear beat counter, go to WRITE; write wins when read_i and write_i are both high.
REQ-021 READ: read_o=1 every cycle; each cycle with resp_i=1 stores burst_i into line_o[s_burst*k +: s_burst], k = beat counter, then increments counter.
REQ-022 READ: when resp_i=1 and counter=num_beats-1, go to READ_DONE; cycles with resp_i=0 store nothing and do not advance.
REQ-023 READ_DONE: resp_o=1 for exactly one cycle, read_o=0, line_o holds the assembled line; next state IDLE.
REQ-024 WRITE: write_o=1 every cycle; burst_o = latched line[s_burst*k +: s_burst] combinationally from counter k; each resp_i=1 advances counter.
REQ-025 WRITE: when resp_i=1 and counter=num_beats-1, go to WRITE_DONE.
REQ-026 WRITE_DONE: resp_o=1 for one cycle, write_o=0; next state IDLE.
REQ-027 read_o and write_o are never high in the same cycle; neither is high in IDLE or a DONE state.
REQ-028 Beat counter is log2(num_beats) bits, never wraps within a transfer, cleared at request acceptance.
REQ-029 Requests are sampled only in IDLE; read_i/write_i during READ/WRITE/DONE states are ignored, so the cycle after resp_o begins in IDLE and a still-asserted request there starts a new transfer.
REQ-030 address_o stays constant from acceptance until return to IDLE; line_o holds its value until the next read's first beat.
REQ-031 Minimum latency: read request to resp_o = num_beats+2 cycles with resp_i continuously high (accept, 4 beats, done).
REQ-032 resp_i in IDLE or a DONE state is ignored.

Reset
REQ-033 rst=1 at a rising edge forces IDLE and clears counter, address_o, line_o and the latched write line to 0.
REQ-034 While and after reset: resp_o=0, read_o=0, write_o=0, burst_o=0; reset mid-transfer abandons it with no resp_o.

Verification
REQ-035 Read, address_i=0x1234_5678, resp_i high 4 cycles with bursts 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x1234_5660, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o one cycle at cycle 6.
REQ-036 Write, line_i=256'h(beats D,C,B,A high-to-low) -> burst_o A,B,C,D in order with write_o high, resp_o one cycle after 4th resp_i, write_o low in that cycle.
REQ-037 Read with resp_i toggling 1,0,0,1,1,0,1 -> exactly 4 beats captured in order, resp_o one cycle after the 7th cycle.
REQ-038 read_i and write_i both high in IDLE -> write transfer only, read_o never asserted.
REQ-039 rst asserted after 2 read beats -> next cycle IDLE, read_o=0, line_o=0, no resp_o; subsequent read completes normally.
REQ-040 Back-to-back write then read with request held through resp_o -> second transfer begins the cycle after resp_o, no extra resp_o pulse.
